// File: rtl/ahb_lite_sdram_wbuf.sv
// AHB-Lite posted-write buffer in front of an SDRAM controller.
// Upstream writes complete with zero wait states while the FIFO has room and
// are drained downstream in order. Upstream reads stall until every earlier
// posted write has been issued, then perform one downstream read.
// Ports:
//   HCLK, HRESET                      clock, synchronous active-high reset
//   S_HSEL/S_HADDR/S_HTRANS/S_HWRITE  upstream address phase
//   S_HSIZE                           ignored (all transfers are 32-bit words)
//   S_HWDATA                          upstream write data (data phase)
//   S_HRDATA/S_HREADY/S_HRESP         upstream response
//   M_HSEL/M_HADDR/M_HTRANS/M_HWRITE/M_HWDATA  downstream master outputs
//   M_HRDATA/M_HREADY                 downstream response
module ahb_lite_sdram_wbuf #(
  parameter int HADDR_BITS = 25,
  parameter int DEPTH      = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  S_HSEL,
  input  logic [HADDR_BITS-1:0] S_HADDR,
  input  logic [1:0]            S_HTRANS,
  input  logic                  S_HWRITE,
  input  logic [2:0]            S_HSIZE,
  input  logic [31:0]           S_HWDATA,
  output logic [31:0]           S_HRDATA,
  output logic                  S_HREADY,
  output logic                  S_HRESP,
  output logic                  M_HSEL,
  output logic [HADDR_BITS-1:0] M_HADDR,
  output logic [1:0]            M_HTRANS,
  output logic                  M_HWRITE,
  output logic [31:0]           M_HWDATA,
  input  logic [31:0]           M_HRDATA,
  input  logic                  M_HREADY
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {M_IDLE, M_WADDR, M_WDATA, M_RADDR, M_RDATA} mstate_t;

  mstate_t r_state, w_next;

  logic [HADDR_BITS-1:0] r_fifo_addr [DEPTH];
  logic [31:0]           r_fifo_data [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;

  logic                  r_dp_valid, r_dp_write;
  logic [HADDR_BITS-1:0] r_dp_addr;
  logic                  r_rd_done;
  logic [31:0]           r_hrdata;

  logic w_full, w_push, w_pop, w_rd_pending, w_hready, w_accept;
  logic w_unused;

  // Fullness uses the count at the start of the cycle, so a pop in the same
  // cycle never lets a stalled write push early.
  assign w_full       = (r_count == FULL);
  assign w_push       = r_dp_valid & r_dp_write & ~w_full;
  assign w_pop        = (r_state == M_WDATA) & M_HREADY;
  assign w_rd_pending = r_dp_valid & ~r_dp_write & ~r_rd_done;
  assign w_hready     = ~r_dp_valid | (r_dp_write ? ~w_full : r_rd_done);
  assign w_accept     = S_HSEL & S_HTRANS[1] & w_hready;

  assign S_HREADY = w_hready;
  assign S_HRDATA = r_hrdata;
  assign S_HRESP  = 1'b0;
  assign M_HSEL   = 1'b1;
  assign w_unused = ^{S_HSIZE, S_HTRANS[0]};

  // Upstream data-phase tracking; held while the current data phase stalls.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else if (w_hready) begin
      r_dp_valid <= w_accept;
      r_dp_write <= S_HWRITE;
      r_dp_addr  <= S_HADDR;
    end
  end

  // Read-done flag: set on downstream capture, cleared as the upstream read
  // data phase completes (S_HREADY is high exactly while it is set).
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rd_done <= 1'b0;
      r_hrdata  <= '0;
    end else if ((r_state == M_RDATA) && M_HREADY) begin
      r_rd_done <= 1'b1;
      r_hrdata  <= M_HRDATA;
    end else if (r_dp_valid && !r_dp_write && r_rd_done) begin
      r_rd_done <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= r_dp_addr;
      r_fifo_data[r_wptr] <= S_HWDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= M_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      M_IDLE: begin
        if (r_count != '0)      w_next = M_WADDR;
        else if (w_rd_pending)  w_next = M_RADDR;
      end
      M_WADDR: if (M_HREADY) w_next = M_WDATA;
      M_WDATA: if (M_HREADY) w_next = M_IDLE;
      M_RADDR: if (M_HREADY) w_next = M_RDATA;
      M_RDATA: if (M_HREADY) w_next = M_IDLE;
      default: w_next = M_IDLE;
    endcase
  end

  always_comb begin
    M_HADDR  = '0;
    M_HTRANS = 2'b00;
    M_HWRITE = 1'b0;
    M_HWDATA = '0;
    unique case (r_state)
      M_WADDR: begin
        M_HADDR  = r_fifo_addr[r_rptr];
        M_HTRANS = 2'b10;
        M_HWRITE = 1'b1;
      end
      M_WDATA: begin
        M_HADDR  = r_fifo_addr[r_rptr];
        M_HWRITE = 1'b1;
        M_HWDATA = r_fifo_data[r_rptr];
      end
      M_RADDR: begin
        M_HADDR  = r_dp_addr;
        M_HTRANS = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_sdram_wbuf.sv
module tb_ahb_lite_sdram_wbuf;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        S_HSEL = 1'b0;
  logic [24:0] S_HADDR = '0;
  logic [1:0]  S_HTRANS = 2'b00;
  logic        S_HWRITE = 1'b0;
  logic [2:0]  S_HSIZE = 3'b010;
  logic [31:0] S_HWDATA = '0;
  logic [31:0] S_HRDATA;
  logic        S_HREADY, S_HRESP, M_HSEL;
  logic [24:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic        M_HWRITE;
  logic [31:0] M_HWDATA;
  logic [31:0] M_HRDATA = '0;
  logic        M_HREADY = 1'b1;

  ahb_lite_sdram_wbuf #(.HADDR_BITS(25), .DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY),
    .S_HRESP(S_HRESP), .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
    .M_HWRITE(M_HWRITE), .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: program-order memory plus expected-response queues.
  logic [31:0] model_mem [logic [24:0]];
  logic [31:0] slave_mem [logic [24:0]];
  logic [56:0] exp_wq [$];
  logic [31:0] exp_rq [$];
  logic        prev_w = 1'b0;
  logic [31:0] prev_wd = '0;
  int          mode = 1;   // 0 random, 1 ready, 2 low, 3 read stall 6, 4 one ready cycle
  int          wr_seen = 0;

  function automatic logic [31:0] init_val(input logic [24:0] a);
    return ({7'b0, a} * 32'h9E37) ^ 32'hA5A50000;
  endfunction

  function automatic logic [31:0] model_rd(input logic [24:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [24:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got no response expected completion", nm);
  endtask

  // One upstream address phase (or idle) while completing the previous data
  // phase; returns the number of stall cycles seen.
  task automatic issue(input bit idle, input bit w, input logic [24:0] a,
                       input logic [31:0] d, output int waits);
    logic rdy;
    S_HSEL   = !idle;
    S_HTRANS = idle ? 2'b00 : 2'b10;
    S_HWRITE = w;
    S_HADDR  = a;
    S_HWDATA = prev_w ? prev_wd : $urandom;
    waits = 0;
    forever begin
      @(negedge HCLK);
      rdy = S_HREADY;
      @(posedge HCLK);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 300) begin
        fail_now("upstream_ready");
        break;
      end
    end
    if (!idle) begin
      if (w) begin
        model_mem[a] = d;
        exp_wq.push_back({a, d});
      end else begin
        exp_rq.push_back(model_rd(a));
      end
    end
    prev_w  = !idle && w;
    prev_wd = d;
  endtask

  task automatic drain();
    int w;
    int n;
    issue(1'b1, 1'b0, '0, '0, w);
    n = 0;
    while ((exp_wq.size() != 0 || exp_rq.size() != 0) && n < 500) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    if (n >= 500) fail_now("drain");
  endtask

  // Upstream monitor: checks read data when a read data phase completes.
  initial begin
    logic rd_dp;
    logic [31:0] e;
    rd_dp = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        rd_dp = 1'b0;
        continue;
      end
      if (rd_dp && S_HREADY) begin
        if (exp_rq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL read_unexpected: got %0h expected no read", S_HRDATA);
        end else begin
          e = exp_rq.pop_front();
          chk("read_data", {32'h0, S_HRDATA}, {32'h0, e});
        end
        rd_dp = 1'b0;
      end
      if (S_HREADY) rd_dp = S_HSEL && S_HTRANS[1] && !S_HWRITE;
    end
  end

  // Downstream slave and write monitor.
  initial begin
    logic        s_dp_valid, s_dp_write;
    logic [24:0] s_dp_addr;
    logic [56:0] e;
    int          stall_cnt;
    s_dp_valid = 1'b0;
    s_dp_write = 1'b0;
    s_dp_addr  = '0;
    stall_cnt  = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        s_dp_valid = 1'b0;
        stall_cnt  = 0;
      end else begin
        if (s_dp_valid && M_HREADY) begin
          if (s_dp_write) begin
            wr_seen++;
            if (exp_wq.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL dn_write_unexpected: got addr %0h expected no write", s_dp_addr);
            end else begin
              e = exp_wq.pop_front();
              chk("dn_wr_addr", {39'h0, s_dp_addr}, {39'h0, e[56:32]});
              chk("dn_wr_data", {32'h0, M_HWDATA}, {32'h0, e[31:0]});
            end
            slave_mem[s_dp_addr] = M_HWDATA;
          end
          s_dp_valid = 1'b0;
          stall_cnt  = 0;
        end
        if (M_HREADY && M_HTRANS[1]) begin
          if (!M_HWRITE) chk("rd_after_writes", 64'(exp_wq.size()), 64'h0);
          s_dp_valid = 1'b1;
          s_dp_write = M_HWRITE;
          s_dp_addr  = M_HADDR;
        end
      end
      @(posedge HCLK);
      #1;
      case (mode)
        0: M_HREADY = ($urandom_range(0, 3) != 0);
        2: M_HREADY = 1'b0;
        3: begin
          if (s_dp_valid && !s_dp_write && stall_cnt < 6) begin
            M_HREADY = 1'b0;
            stall_cnt++;
          end else begin
            M_HREADY = 1'b1;
          end
        end
        4: begin
          M_HREADY = 1'b1;
          mode = 2;
        end
        default: M_HREADY = 1'b1;
      endcase
      M_HRDATA = (s_dp_valid && !s_dp_write) ? slave_rd(s_dp_addr) : $urandom;
    end
  end

  initial begin
    int w;
    int snap;
    logic [31:0] d0;
    logic [24:0] a;
    logic [31:0] saved [logic [24:0]];

    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_s_hready", {63'h0, S_HREADY}, 64'h1);
    chk("rst_s_hrdata", {32'h0, S_HRDATA}, 64'h0);
    chk("rst_m_htrans", {62'h0, M_HTRANS}, 64'h0);
    chk("rst_m_hwrite", {63'h0, M_HWRITE}, 64'h0);
    chk("rst_m_haddr",  {39'h0, M_HADDR}, 64'h0);
    chk("rst_m_hwdata", {32'h0, M_HWDATA}, 64'h0);
    chk("rst_s_hresp",  {63'h0, S_HRESP}, 64'h0);
    chk("m_hsel",       {63'h0, M_HSEL}, 64'h1);
    @(posedge HCLK);
    #1;

    // Four back-to-back writes, downstream always ready: no upstream waits.
    mode = 1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 25'(32'h10 + 4 * i), 32'h11111111 * (i + 1), w);
      chk("zero_wait_addr", 64'(w), 64'h0);
    end
    issue(1'b1, 1'b0, '0, '0, w);
    chk("zero_wait_last", 64'(w), 64'h0);
    drain();

    // Downstream held low: fifth write data phase stalls until the first pop.
    mode = 2;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b1, 25'(32'h20 + 4 * i), $urandom, w);
      chk("fill_wait", 64'(w), 64'h0);
    end
    S_HSEL   = 1'b0;
    S_HTRANS = 2'b00;
    S_HWDATA = prev_wd;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("full_stall", {63'h0, S_HREADY}, 64'h0);
      if (i == 2) mode = 1;
      @(posedge HCLK);
      #1;
    end
    issue(1'b1, 1'b0, '0, '0, w);
    chk("full_release_waits", 64'(w), 64'h2);
    drain();

    // Two writes then a read of the first address: ordering kept.
    mode = 0;
    issue(1'b0, 1'b1, 25'h10, $urandom, w);
    issue(1'b0, 1'b1, 25'h14, $urandom, w);
    issue(1'b0, 1'b0, 25'h10, '0, w);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      a = 25'(32'h10 + 4 * $urandom_range(0, 15));
      if (r < 5)      issue(1'b0, 1'b1, a, $urandom, w);
      else if (r < 8) issue(1'b0, 1'b0, a, '0, w);
      else            issue(1'b1, 1'b0, '0, '0, w);
    end
    drain();

    // Read with empty FIFO, downstream stalls 6 cycles in the data phase.
    mode = 3;
    model_mem[25'h80] = 32'hDEADBEEF;
    slave_mem[25'h80] = 32'hDEADBEEF;
    issue(1'b0, 1'b0, 25'h80, '0, w);
    issue(1'b1, 1'b0, '0, '0, w);
    chk("stall_read_waits", 64'(w), 64'd9);
    mode = 1;
    drain();

    // Reset in the write data phase with three writes posted.
    saved = model_mem;
    mode = 2;
    d0 = $urandom;
    issue(1'b0, 1'b1, 25'h30, d0, w);
    issue(1'b0, 1'b1, 25'h34, $urandom, w);
    issue(1'b0, 1'b1, 25'h38, $urandom, w);
    issue(1'b1, 1'b0, '0, '0, w);
    mode = 4;
    repeat (4) @(negedge HCLK);
    chk("wdata_htrans", {62'h0, M_HTRANS}, 64'h0);
    chk("wdata_hold",   {32'h0, M_HWDATA}, {32'h0, d0});
    @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    exp_wq.delete();
    model_mem = saved;
    @(negedge HCLK);
    chk("post_rst_htrans", {62'h0, M_HTRANS}, 64'h0);
    chk("post_rst_hready", {63'h0, S_HREADY}, 64'h1);
    chk("post_rst_hwrite", {63'h0, M_HWRITE}, 64'h0);
    snap = wr_seen;
    mode = 0;
    repeat (30) @(posedge HCLK);
    #1;
    chk("no_write_after_rst", 64'(wr_seen - snap), 64'h0);
    issue(1'b0, 1'b0, 25'h30, '0, w);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
